// File: rtl/emc_stim_pkg.sv
// Shared types and config-address constants for the EMC stimulus sequencer.
package emc_stim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RST_HOLD,
    RUN,
    DONE
  } top_state_t;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_DELAY,
    CH_LOW,
    CH_HIGH,
    CH_DONE
  } ch_state_t;

  localparam logic [1:0] CFG_DELAY = 2'd0;
  localparam logic [1:0] CFG_LOW   = 2'd1;
  localparam logic [1:0] CFG_HIGH  = 2'd2;
  localparam logic [1:0] CFG_COUNT = 2'd3;

endpackage

// File: rtl/emc_stim_channel.sv
// One pulse channel: config registers, phase/pulse counters and the channel FSM.
module emc_stim_channel
  import emc_stim_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_addr,
  input  logic [CNT_W-1:0] i_cfg_wdata,
  output logic             o_out,
  output logic             o_busy,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_low;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_dur;
  logic [CNT_W-1:0] r_pcnt;
  ch_state_t        r_state;
  logic             r_out;
  logic             r_busy;

  ch_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_dur_nxt;
  logic [CNT_W-1:0] w_pcnt_nxt;
  logic [CNT_W-1:0] w_low_m1;
  logic [CNT_W-1:0] w_high_m1;
  logic [CNT_W-1:0] w_pcnt_inc;

  // Zero-length LOW/HIGH phases are stretched to one cycle.
  assign w_low_m1   = (r_low  == '0) ? '0 : r_low  - CNT_W'(1);
  assign w_high_m1  = (r_high == '0) ? '0 : r_high - CNT_W'(1);
  assign w_pcnt_inc = r_pcnt + CNT_W'(1);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_delay <= '0;
      r_low   <= '0;
      r_high  <= '0;
      r_count <= '0;
    end else if (i_cfg_we) begin
      case (i_cfg_addr)
        CFG_DELAY: r_delay <= i_cfg_wdata;
        CFG_LOW:   r_low   <= i_cfg_wdata;
        CFG_HIGH:  r_high  <= i_cfg_wdata;
        default:   r_count <= i_cfg_wdata;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= CH_IDLE;
      r_dur   <= '0;
      r_pcnt  <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dur   <= w_dur_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_out   <= (w_state_nxt == CH_HIGH);
      r_busy  <= (w_state_nxt == CH_DELAY) || (w_state_nxt == CH_LOW) ||
                 (w_state_nxt == CH_HIGH);
    end
  end

  // Duration counter holds remaining cycles minus one; reloaded on each phase entry.
  always_comb begin
    w_state_nxt = r_state;
    w_dur_nxt   = r_dur;
    w_pcnt_nxt  = r_pcnt;
    if (i_abort) begin
      w_state_nxt = CH_IDLE;
    end else begin
      case (r_state)
        CH_IDLE: begin
          if (i_start) begin
            w_pcnt_nxt = '0;
            if (r_delay != '0) begin
              w_state_nxt = CH_DELAY;
              w_dur_nxt   = r_delay - CNT_W'(1);
            end else begin
              w_state_nxt = CH_LOW;
              w_dur_nxt   = w_low_m1;
            end
          end
        end
        CH_DELAY: begin
          if (r_dur == '0) begin
            w_state_nxt = CH_LOW;
            w_dur_nxt   = w_low_m1;
          end else begin
            w_dur_nxt = r_dur - CNT_W'(1);
          end
        end
        CH_LOW: begin
          if (r_dur == '0) begin
            w_state_nxt = CH_HIGH;
            w_dur_nxt   = w_high_m1;
          end else begin
            w_dur_nxt = r_dur - CNT_W'(1);
          end
        end
        CH_HIGH: begin
          if (r_dur == '0) begin
            if (r_count == '0) begin
              w_state_nxt = CH_LOW;
              w_dur_nxt   = w_low_m1;
            end else if (w_pcnt_inc == r_count) begin
              w_state_nxt = CH_DONE;
              w_pcnt_nxt  = w_pcnt_inc;
            end else begin
              w_state_nxt = CH_LOW;
              w_dur_nxt   = w_low_m1;
              w_pcnt_nxt  = w_pcnt_inc;
            end
          end else begin
            w_dur_nxt = r_dur - CNT_W'(1);
          end
        end
        CH_DONE: w_state_nxt = CH_DONE;
        default: w_state_nxt = CH_IDLE;
      endcase
    end
  end

  assign o_out    = r_out;
  assign o_busy   = r_busy;
  assign o_done_c = (w_state_nxt == CH_DONE);

endmodule

// File: rtl/emc_stim_sequencer.sv
// Device reset sequencing followed by N_CH programmable pulse trains.
module emc_stim_sequencer
  import emc_stim_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RST_CYCLES = 4,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             CFG_WE,
  input  logic [CH_W-1:0]  CFG_CH,
  input  logic [1:0]       CFG_ADDR,
  input  logic [CNT_W-1:0] CFG_WDATA,
  output logic             RST_OUT_B,
  output logic [N_CH-1:0]  CH_OUT,
  output logic [N_CH-1:0]  CH_BUSY,
  output logic             SEQ_DONE
);

  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  top_state_t        r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_rst_out_b;
  logic              r_seq_done;

  top_state_t        w_state_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_start;
  logic              w_abort;
  logic [N_CH-1:0]   w_cfg_we;
  logic [N_CH-1:0]   w_ch_done_c;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_rst_out_b <= 1'b0;
      r_seq_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_rst_out_b <= (w_state_nxt == RUN) || (w_state_nxt == DONE);
      r_seq_done  <= (w_state_nxt == DONE);
    end
  end

  // Hold counter counts RST_CYCLES-1 down to 0, giving exactly RST_CYCLES hold cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_start     = 1'b0;
    w_abort     = (r_state != IDLE) && !EN;
    case (r_state)
      IDLE: begin
        if (EN) begin
          w_state_nxt = RST_HOLD;
          w_hold_nxt  = HOLD_W'(RST_CYCLES - 1);
        end
      end
      RST_HOLD: begin
        if (!EN) begin
          w_state_nxt = IDLE;
        end else if (r_hold == '0) begin
          w_state_nxt = RUN;
          w_start     = 1'b1;
        end else begin
          w_hold_nxt = r_hold - HOLD_W'(1);
        end
      end
      RUN: begin
        if (!EN) begin
          w_state_nxt = IDLE;
        end else if (&w_ch_done_c) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (!EN) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Channel-select decode; out-of-range CFG_CH matches no channel.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_cfg_we[i] = CFG_WE && (r_state == IDLE) && (CFG_CH == CH_W'(i));

    emc_stim_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .i_start    (w_start),
      .i_abort    (w_abort),
      .i_cfg_we   (w_cfg_we[i]),
      .i_cfg_addr (CFG_ADDR),
      .i_cfg_wdata(CFG_WDATA),
      .o_out      (CH_OUT[i]),
      .o_busy     (CH_BUSY[i]),
      .o_done_c   (w_ch_done_c[i])
    );
  end

  assign RST_OUT_B = r_rst_out_b;
  assign SEQ_DONE  = r_seq_done;

endmodule

// File: tb/tb_emc_stim_sequencer.sv
// Scoreboard bench: expected per-edge output vectors come from a timeline model of the programmed trains.
module tb_emc_stim_sequencer;
  import emc_stim_pkg::*;

  localparam int unsigned RST_CYC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        rst_out_b;
  logic [1:0]  ch_out;
  logic [1:0]  ch_busy;
  logic        seq_done;

  logic        en3;
  logic        we3;
  logic [1:0]  ch3;
  logic [1:0]  addr3;
  logic [15:0] wdata3;
  logic        rst_out_b3;
  logic [2:0]  ch_out3;
  logic [2:0]  ch_busy3;
  logic        seq_done3;

  emc_stim_sequencer #(.N_CH(2), .CNT_W(16), .RST_CYCLES(RST_CYC)) u_dut (
    .CLOCK(clk), .RESET(rst), .EN(en), .CFG_WE(cfg_we), .CFG_CH(cfg_ch),
    .CFG_ADDR(cfg_addr), .CFG_WDATA(cfg_wdata), .RST_OUT_B(rst_out_b),
    .CH_OUT(ch_out), .CH_BUSY(ch_busy), .SEQ_DONE(seq_done)
  );

  // Three-channel instance gives CFG_CH an unused code to exercise out-of-range writes.
  emc_stim_sequencer #(.N_CH(3), .CNT_W(16), .RST_CYCLES(RST_CYC)) u_dut3 (
    .CLOCK(clk), .RESET(rst), .EN(en3), .CFG_WE(we3), .CFG_CH(ch3),
    .CFG_ADDR(addr3), .CFG_WDATA(wdata3), .RST_OUT_B(rst_out_b3),
    .CH_OUT(ch_out3), .CH_BUSY(ch_busy3), .SEQ_DONE(seq_done3)
  );

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   run_id   = 0;
  int   cfg_d[2];
  int   cfg_l[2];
  int   cfg_h[2];
  int   cfg_c[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {RST_OUT_B, CH_OUT[1:0], CH_BUSY[1:0], SEQ_DONE} after edge e of a run.
  function automatic logic [5:0] model_at(input int e);
    logic [1:0] o;
    logic [1:0] b;
    logic       all_fin;
    int         k, lm, hm, p, t;
    if (e < int'(RST_CYC)) return 6'b0;
    k       = e - int'(RST_CYC);
    all_fin = 1'b1;
    o       = 2'b0;
    b       = 2'b0;
    for (int c = 0; c < 2; c++) begin
      lm = (cfg_l[c] == 0) ? 1 : cfg_l[c];
      hm = (cfg_h[c] == 0) ? 1 : cfg_h[c];
      p  = lm + hm;
      if (k < cfg_d[c]) begin
        b[c]    = 1'b1;
        all_fin = 1'b0;
      end else begin
        t = k - cfg_d[c];
        if (!(cfg_c[c] != 0 && t >= cfg_c[c] * p)) begin
          b[c]    = 1'b1;
          o[c]    = ((t % p) >= lm);
          all_fin = 1'b0;
        end
      end
    end
    return {1'b1, o, b, all_fin};
  endfunction

  task automatic push_run(input int n_edges);
    exp_t x;
    run_id++;
    for (int e = 0; e < n_edges; e++) begin
      x.tag = $sformatf("run%0d_e%0d", run_id, e);
      x.val = model_at(e);
      sb_q.push_back(x);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t x;
    for (int e = 0; e < n; e++) begin
      x.tag = $sformatf("abort%0d_e%0d", run_id, e);
      x.val = 6'b0;
      sb_q.push_back(x);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int lim;
    int n;
    lim = sb_q.size() + 20;
    n   = 0;
    while (sb_q.size() > 0 && n < lim) begin
      step(1);
      n++;
    end
    check_val("drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] addr, input int data);
    cfg_we    = 1'b1;
    cfg_ch    = 1'(ch);
    cfg_addr  = addr;
    cfg_wdata = 16'(data);
    step(1);
    cfg_we    = 1'b0;
  endtask

  task automatic cfg3_write(input int ch, input logic [1:0] addr, input int data);
    we3    = 1'b1;
    ch3    = 2'(ch);
    addr3  = addr;
    wdata3 = 16'(data);
    step(1);
    we3    = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (sb_q.size() != 0) begin
      x = sb_q.pop_front();
      check_val(x.tag, {26'b0, rst_out_b, ch_out, ch_busy, seq_done}, {26'b0, x.val});
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
    en3 = 1'b0; we3 = 1'b0; ch3 = '0; addr3 = '0; wdata3 = '0;
    for (int c = 0; c < 2; c++) begin
      cfg_d[c] = 0; cfg_l[c] = 0; cfg_h[c] = 0; cfg_c[c] = 0;
    end

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check_val("rst_rst_out_b", 32'(rst_out_b), 32'd0);
    check_val("rst_ch_out",    32'(ch_out),    32'd0);
    check_val("rst_ch_busy",   32'(ch_busy),   32'd0);
    check_val("rst_seq_done",  32'(seq_done),  32'd0);
    step(2);
    rst = 1'b0;
    step(1);

    // Finite trains
    cfg_write(0, CFG_DELAY, 0); cfg_write(0, CFG_LOW, 2);
    cfg_write(0, CFG_HIGH, 3);  cfg_write(0, CFG_COUNT, 2);
    cfg_write(1, CFG_DELAY, 3); cfg_write(1, CFG_LOW, 1);
    cfg_write(1, CFG_HIGH, 1);  cfg_write(1, CFG_COUNT, 1);
    cfg_d[0] = 0; cfg_l[0] = 2; cfg_h[0] = 3; cfg_c[0] = 2;
    cfg_d[1] = 3; cfg_l[1] = 1; cfg_h[1] = 1; cfg_c[1] = 1;

    en = 1'b1;
    push_run(24);
    step(8);
    cfg_write(0, CFG_HIGH, 9);  // issued during RUN, must not take effect
    drain();
    en = 1'b0;
    push_idle(2);
    drain();

    // Abort mid-HIGH of ch0 (edge 11 leaves ch0 in its second high cycle)
    en = 1'b1;
    push_run(12);
    drain();
    en = 1'b0;
    push_idle(2);
    drain();

    // Replay with retained configuration
    en = 1'b1;
    push_run(20);
    drain();
    en = 1'b0;
    push_idle(2);
    drain();

    // Continuous PHT-style pattern on ch0: 500 low / 200 high
    cfg_write(0, CFG_LOW, 500); cfg_write(0, CFG_HIGH, 200); cfg_write(0, CFG_COUNT, 0);
    cfg_l[0] = 500; cfg_h[0] = 200; cfg_c[0] = 0;
    en = 1'b1;
    push_run(int'(RST_CYC) + 7000);
    drain();
    en = 1'b0;
    push_idle(2);
    drain();

    // Async reset mid-RUN during ch0 high phase
    en = 1'b1;
    push_run(int'(RST_CYC) + 600);
    drain();
    #2 rst = 1'b1;
    #1;
    check_val("midrst_rst_out_b", 32'(rst_out_b), 32'd0);
    check_val("midrst_ch_out",    32'(ch_out),    32'd0);
    check_val("midrst_ch_busy",   32'(ch_busy),   32'd0);
    check_val("midrst_seq_done",  32'(seq_done),  32'd0);
    en = 1'b0;
    step(1);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cfg_d[c] = 0; cfg_l[c] = 0; cfg_h[c] = 0; cfg_c[c] = 0;
    end
    step(1);
    en = 1'b1;
    push_run(int'(RST_CYC) + 20);
    drain();
    en = 1'b0;
    push_idle(2);
    drain();

    // Out-of-range channel writes ignored; LOW=0/HIGH=0 act as one cycle
    for (int c = 0; c < 3; c++) cfg3_write(c, CFG_COUNT, 1);
    cfg3_write(3, CFG_COUNT, 0);
    cfg3_write(3, CFG_DELAY, 5);
    en3 = 1'b1;
    step(6);
    check_val("ch3_out_e5",  32'(ch_out3),   32'h7);
    check_val("ch3_busy_e5", 32'(ch_busy3),  32'h7);
    check_val("ch3_done_e5", 32'(seq_done3), 32'd0);
    step(1);
    check_val("ch3_done_e6",  32'(seq_done3),  32'd1);
    check_val("ch3_out_e6",   32'(ch_out3),    32'd0);
    check_val("ch3_busy_e6",  32'(ch_busy3),   32'd0);
    check_val("ch3_rstb_e6",  32'(rst_out_b3), 32'd1);
    en3 = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
